lutram_cfg_write_ctrl: RTL and testbench



---
 rtl/lutram_cfg_write_ctrl.sv | 159 +++++++++++++++
 tb/tb_lutram_cfg_write_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lutram_cfg_write_ctrl.sv
// rtl/lutram_cfg_write_ctrl.sv - LUT-RAM config loader and round-robin single-bit write arbiter
// Optional even-parity check per config word: LUTRAM_CFG_PARITY_EN
module lutram_cfg_write_ctrl #(
  parameter int ADDR_BITS = 4,
  parameter int MEM_SIZE  = 2**ADDR_BITS,
  parameter int NUM_LUTS  = 4,
  parameter int SEL_BITS  = (NUM_LUTS > 1) ? $clog2(NUM_LUTS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_start,
  input  logic                 cfg_valid,
  input  logic                 cfg_bit,
  output logic                 cfg_ready,
  output logic                 cfg_busy,
  output logic                 cfg_done,
  output logic                 cfg_err,
  output logic [MEM_SIZE-1:0]  config_out,
  output logic [NUM_LUTS-1:0]  cen_out,
  input  logic                 req0_valid,
  input  logic                 req1_valid,
  output logic                 req0_ready,
  output logic                 req1_ready,
  input  logic [SEL_BITS-1:0]  req0_lut,
  input  logic [SEL_BITS-1:0]  req1_lut,
  input  logic [ADDR_BITS-1:0] req0_addr,
  input  logic [ADDR_BITS-1:0] req1_addr,
  input  logic                 req0_data,
  input  logic                 req1_data,
  output logic [NUM_LUTS-1:0]  write_en,
  output logic [ADDR_BITS-1:0] waddr,
  output logic                 data_in
);

  localparam int CNT_W = $clog2(MEM_SIZE + 1);
`ifdef LUTRAM_CFG_PARITY_EN
  localparam int LAST_BIT = MEM_SIZE;
`else
  localparam int LAST_BIT = MEM_SIZE - 1;
`endif
  localparam logic [NUM_LUTS-1:0] ONE = NUM_LUTS'(1);

  typedef enum logic [1:0] {IDLE, SHIFT, LOAD, DONE} state_t;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     bit_cnt;
  logic [SEL_BITS-1:0]  lut_cnt;
  logic [MEM_SIZE-1:0]  shreg;
  logic [MEM_SIZE-1:0]  word_q;
  logic                 rr;
  logic                 take_bit;
  logic                 last_bit;
  logic                 par_bad;
  logic                 arb_en;
  logic                 grant0;
  logic                 grant1;

  assign take_bit = (state == SHIFT) && cfg_valid;
  assign last_bit = (bit_cnt == CNT_W'(LAST_BIT));

`ifdef LUTRAM_CFG_PARITY_EN
  logic err_q;
  // The parity bit arrives after the full word is already in shreg
  assign par_bad = take_bit && last_bit && (cfg_bit != ^shreg);
  assign cfg_err = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (state == IDLE && cfg_start) begin
      err_q <= 1'b0;
    end else if (par_bad) begin
      err_q <= 1'b1;
    end
  end
`else
  assign par_bad = 1'b0;
  assign cfg_err = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cfg_start) state_nxt = SHIFT;
      SHIFT:   if (take_bit && last_bit) state_nxt = par_bad ? DONE : LOAD;
      LOAD:    state_nxt = (lut_cnt == SEL_BITS'(NUM_LUTS - 1)) ? DONE : SHIFT;
      default: state_nxt = IDLE;
    endcase
  end

  assign cfg_ready  = (state == SHIFT);
  assign cfg_busy   = (state != IDLE);
  assign cfg_done   = (state == DONE);
  assign cen_out    = (state == LOAD) ? (ONE << lut_cnt) : '0;
  assign config_out = (state == LOAD) ? shreg : word_q;

  // Arbitration is frozen while configuring and in the cycle configuration starts
  assign arb_en = !rst && (state == IDLE) && !cfg_start;
  assign grant0 = arb_en && req0_valid && (!req1_valid || !rr);
  assign grant1 = arb_en && req1_valid && (!req0_valid || rr);
  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      lut_cnt  <= '0;
      shreg    <= '0;
      word_q   <= '0;
      rr       <= 1'b0;
      write_en <= '0;
      waddr    <= '0;
      data_in  <= 1'b0;
    end else begin
      state    <= state_nxt;
      write_en <= '0;
      case (state)
        IDLE: begin
          if (cfg_start) begin
            bit_cnt <= '0;
            lut_cnt <= '0;
          end
        end
        SHIFT: begin
          if (take_bit) begin
            if (bit_cnt < CNT_W'(MEM_SIZE)) shreg[bit_cnt[ADDR_BITS-1:0]] <= cfg_bit;
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        LOAD: begin
          word_q <= shreg;
          if (state_nxt == SHIFT) begin
            lut_cnt <= lut_cnt + 1'b1;
            bit_cnt <= '0;
          end
        end
        default: ;
      endcase
      // Out-of-range LUT selects are acknowledged but never strobe a block
      if (grant0) begin
        rr <= 1'b1;
        if (int'(req0_lut) < NUM_LUTS) begin
          write_en <= ONE << req0_lut;
          waddr    <= req0_addr;
          data_in  <= req0_data;
        end
      end else if (grant1) begin
        rr <= 1'b0;
        if (int'(req1_lut) < NUM_LUTS) begin
          write_en <= ONE << req1_lut;
          waddr    <= req1_addr;
          data_in  <= req1_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_lutram_cfg_write_ctrl.sv
// tb/tb_lutram_cfg_write_ctrl.sv - scoreboard bench for lutram_cfg_write_ctrl (honours LUTRAM_CFG_PARITY_EN)
module tb_lutram_cfg_write_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        cfg_start = 1'b0, cfg_valid = 1'b0, cfg_bit = 1'b0;
  logic        cfg_ready, cfg_busy, cfg_done, cfg_err;
  logic [15:0] config_out;
  logic [3:0]  cen_out;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [1:0]  req0_lut = '0, req1_lut = '0;
  logic [3:0]  req0_addr = '0, req1_addr = '0;
  logic        req0_data = 1'b0, req1_data = 1'b0;
  logic [3:0]  write_en;
  logic [3:0]  waddr;
  logic        data_in;

  // Second instance with a non-power-of-two LUT count so an out-of-range select is expressible
  logic        r3_valid0 = 1'b0, r3_valid1 = 1'b0;
  logic [1:0]  r3_lut0 = '0, r3_lut1 = '0;
  logic [3:0]  r3_addr0 = '0, r3_addr1 = '0;
  logic        r3_data0 = 1'b0, r3_data1 = 1'b0;
  logic        r3_ready0, r3_ready1;
  logic        d3_ready, d3_busy, d3_done, d3_err;
  logic [15:0] d3_config;
  logic [2:0]  d3_cen, d3_we;
  logic [3:0]  d3_waddr;
  logic        d3_data;

  int tests = 0;
  int fails = 0;

  typedef struct packed {logic [3:0] cen; logic [15:0] word;} cen_t;
  typedef struct packed {logic [3:0] we; logic [3:0] addr; logic data;} wr_t;
  cen_t exp_cen[$];
  wr_t  exp_wr[$];

  lutram_cfg_write_ctrl #(.ADDR_BITS(4), .NUM_LUTS(4)) u_dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_bit(cfg_bit),
    .cfg_ready(cfg_ready), .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_err(cfg_err),
    .config_out(config_out), .cen_out(cen_out),
    .req0_valid(req0_valid), .req1_valid(req1_valid), .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_lut(req0_lut), .req1_lut(req1_lut), .req0_addr(req0_addr), .req1_addr(req1_addr),
    .req0_data(req0_data), .req1_data(req1_data),
    .write_en(write_en), .waddr(waddr), .data_in(data_in)
  );

  lutram_cfg_write_ctrl #(.ADDR_BITS(4), .NUM_LUTS(3)) u_dut3 (
    .clk(clk), .rst(rst), .cfg_start(1'b0), .cfg_valid(1'b0), .cfg_bit(1'b0),
    .cfg_ready(d3_ready), .cfg_busy(d3_busy), .cfg_done(d3_done), .cfg_err(d3_err),
    .config_out(d3_config), .cen_out(d3_cen),
    .req0_valid(r3_valid0), .req1_valid(r3_valid1), .req0_ready(r3_ready0), .req1_ready(r3_ready1),
    .req0_lut(r3_lut0), .req1_lut(r3_lut1), .req0_addr(r3_addr0), .req1_addr(r3_addr1),
    .req0_data(r3_data0), .req1_data(r3_data1),
    .write_en(d3_we), .waddr(d3_waddr), .data_in(d3_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; cfg_start = 1'b0; cfg_valid = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; r3_valid0 = 1'b0; r3_valid1 = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    tests++;
    if ({cfg_ready, cfg_busy, cfg_done, cfg_err} !== 4'b0) begin
      fails++; $display("FAIL reset_status: got %b want 0000", {cfg_ready, cfg_busy, cfg_done, cfg_err});
    end
    tests++;
    if (config_out !== 16'h0 || cen_out !== 4'h0) begin
      fails++; $display("FAIL reset_cfg_out: got cfg=%h cen=%b want 0/0", config_out, cen_out);
    end
    tests++;
    if ({write_en, waddr, data_in, req0_ready, req1_ready} !== 11'b0 || d3_we !== 3'b0) begin
      fails++; $display("FAIL reset_wr_port: got we=%b a=%h d=%b rdy=%b%b we3=%b want 0",
                        write_en, waddr, data_in, req0_ready, req1_ready, d3_we);
    end
    rst = 1'b0;
    tick();
    tests++;
    if (cfg_busy !== 1'b0 || cfg_ready !== 1'b0 || cen_out !== 4'h0) begin
      fails++; $display("FAIL idle_after_reset: got busy=%b ready=%b cen=%b want 0", cfg_busy, cfg_ready, cen_out);
    end
  endtask

  task automatic run_config(input bit gapped, input bit hold_req, input int bad_word);
    logic [15:0] words [4];
    logic [15:0] last_word;
    bit   bits[$];
    bit   ph, done, p;
    int   cyc, last_load;
    cen_t e;
    words[0] = 16'hA5A5; words[1] = 16'h0001; words[2] = 16'h8000; words[3] = 16'hFFFF;
    exp_cen.delete();
    for (int w = 0; w < 4; w++) begin
      for (int b = 0; b < 16; b++) bits.push_back(words[w][b]);
`ifdef LUTRAM_CFG_PARITY_EN
      p = ^words[w];
      if (w == bad_word) p = ~p;
      bits.push_back(p);
`endif
      if (bad_word < 0 || w < bad_word) exp_cen.push_back('{cen: 4'(1 << w), word: words[w]});
    end
    last_word = (bad_word > 0) ? words[bad_word - 1] : words[3];

    tick();
    cfg_start = 1'b1;
    if (hold_req) begin
      req0_valid = 1'b1; req0_lut = 2'd3; req0_addr = 4'd9; req0_data = 1'b1;
      #1;
      tests++;
      if (req0_ready !== 1'b0) begin
        fails++; $display("FAIL grant_in_start_cycle: got ready=%b want 0", req0_ready);
      end
    end
    tick();
    cfg_start = 1'b0;
    ph = 1'b1; done = 1'b0; cyc = 0; last_load = -10;
    while (!done && cyc < 600) begin
      if (cen_out !== 4'h0) begin
        tests++;
        if (exp_cen.size() == 0) begin
          fails++; $display("FAIL cen_unexpected: got cen=%b word=%h want none", cen_out, config_out);
        end else begin
          e = exp_cen.pop_front();
          if (cen_out !== e.cen || config_out !== e.word) begin
            fails++; $display("FAIL load_word: got cen=%b word=%h want cen=%b word=%h", cen_out, config_out, e.cen, e.word);
          end
        end
        tests++;
        if (cfg_ready !== 1'b0) begin
          fails++; $display("FAIL ready_in_load: got %b want 0", cfg_ready);
        end
        last_load = cyc;
      end
      if (hold_req && (req0_ready !== 1'b0 || write_en !== 4'h0)) begin
        tests++; fails++;
        $display("FAIL write_during_cfg: got ready=%b we=%b want 0/0", req0_ready, write_en);
      end
      if (cfg_done === 1'b1) begin
        done = 1'b1;
        tests++;
        if (bad_word < 0 && cyc != last_load + 1) begin
          fails++; $display("FAIL done_timing: got done %0d cycles after last load want 1", cyc - last_load);
        end
        tests++;
        if (exp_cen.size() != 0 || cfg_err !== (bad_word >= 0)) begin
          fails++; $display("FAIL done_state: got %0d loads missing err=%b want 0 missing err=%b",
                            exp_cen.size(), cfg_err, bad_word >= 0);
        end
      end else begin
        cfg_valid = (bits.size() != 0) && (gapped ? ph : 1'b1);
        cfg_bit   = (bits.size() != 0) ? bits[0] : 1'b0;
        ph = ~ph;
        if (cfg_valid && cfg_ready) void'(bits.pop_front());
        tick();
        cyc++;
      end
    end
    cfg_valid = 1'b0;
    if (!done) begin
      tests++; fails++;
      $display("FAIL cfg_timeout: got no cfg_done in %0d cycles want done", cyc);
    end
    tick();
    tests++;
    if (cfg_busy !== 1'b0 || config_out !== last_word || cfg_done !== 1'b0) begin
      fails++; $display("FAIL post_cfg_idle: got busy=%b cfg=%h done=%b want 0/%h/0", cfg_busy, config_out, cfg_done, last_word);
    end
    if (hold_req) begin
      tests++;
      if (req0_ready !== 1'b1) begin
        fails++; $display("FAIL first_idle_grant: got ready=%b want 1", req0_ready);
      end
      tick();
      req0_valid = 1'b0;
      tests++;
      if (write_en !== 4'b1000 || waddr !== 4'd9 || data_in !== 1'b1) begin
        fails++; $display("FAIL held_write: got we=%b a=%h d=%b want 1000/9/1", write_en, waddr, data_in);
      end
    end
  endtask

  task automatic test_full_config();
    apply_reset();
    run_config(1'b0, 1'b0, -1);
  endtask

  task automatic test_gapped_config();
    run_config(1'b1, 1'b0, -1);
  endtask

  task automatic test_writes_during_config();
    run_config(1'b0, 1'b1, -1);
  endtask

  task automatic test_contention();
    bit  rr_m;
    wr_t e;
    apply_reset();
    rr_m = 1'b0;
    exp_wr.delete();
    req0_lut = 2'd1; req0_addr = 4'd3; req0_data = 1'b1;
    req1_lut = 2'd2; req1_addr = 4'd7; req1_data = 1'b0;
    tick();
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (req0_ready !== !rr_m || req1_ready !== rr_m) begin
        fails++; $display("FAIL rr_grant%0d: got %b%b want %b%b", k, req0_ready, req1_ready, !rr_m, rr_m);
      end
      exp_wr.push_back(rr_m ? '{we: 4'b0100, addr: 4'd7, data: 1'b0} : '{we: 4'b0010, addr: 4'd3, data: 1'b1});
      rr_m = ~rr_m;
      tick();
      if (k == 3) begin req0_valid = 1'b0; req1_valid = 1'b0; end
      e = exp_wr.pop_front();
      tests++;
      if (write_en !== e.we || waddr !== e.addr || data_in !== e.data) begin
        fails++; $display("FAIL rr_write%0d: got we=%b a=%h d=%b want %b/%h/%b", k, write_en, waddr, data_in, e.we, e.addr, e.data);
      end
      #1;
    end
    tick();
    tests++;
    if (write_en !== 4'h0) begin
      fails++; $display("FAIL write_one_cycle: got we=%b want 0000", write_en);
    end
  endtask

  task automatic test_out_of_range();
    apply_reset();
    r3_lut0 = 2'd3; r3_addr0 = 4'd4; r3_data0 = 1'b1;
    r3_lut1 = 2'd2; r3_addr1 = 4'd5; r3_data1 = 1'b1;
    r3_valid0 = 1'b1; r3_valid1 = 1'b1;
    #1;
    tests++;
    if (r3_ready0 !== 1'b1 || r3_ready1 !== 1'b0) begin
      fails++; $display("FAIL oor_grant: got %b%b want 10", r3_ready0, r3_ready1);
    end
    tick();
    r3_valid0 = 1'b0;
    tests++;
    if (d3_we !== 3'b000) begin
      fails++; $display("FAIL oor_dropped: got we=%b want 000", d3_we);
    end
    #1;
    tests++;
    if (r3_ready1 !== 1'b1) begin
      fails++; $display("FAIL oor_next_grant: got %b want 1", r3_ready1);
    end
    tick();
    r3_valid1 = 1'b0;
    tests++;
    if (d3_we !== 3'b100 || d3_waddr !== 4'd5 || d3_data !== 1'b1) begin
      fails++; $display("FAIL inrange_write: got we=%b a=%h d=%b want 100/5/1", d3_we, d3_waddr, d3_data);
    end
  endtask

  task automatic test_mid_config_reset();
    int accepted, cens, dones, cyc;
    apply_reset();
    tick();
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    accepted = 0; cens = 0; dones = 0; cyc = 0;
    while (accepted < 20 && cyc < 100) begin
      if (cen_out !== 4'h0) begin
        cens++;
        tests++;
        if (cen_out !== 4'b0001 || config_out !== 16'hFFFF) begin
          fails++; $display("FAIL partial_load: got cen=%b word=%h want 0001/ffff", cen_out, config_out);
        end
      end
      if (cfg_done === 1'b1) dones++;
      cfg_valid = 1'b1;
      cfg_bit = 1'b1;
`ifdef LUTRAM_CFG_PARITY_EN
      if (accepted == 16) cfg_bit = 1'b0;
`endif
      if (cfg_ready) accepted++;
      tick();
      cyc++;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (cen_out !== 4'h0) cens++;
      if (cfg_done === 1'b1) dones++;
      if (cfg_busy !== 1'b0 || cfg_ready !== 1'b0 || config_out !== 16'h0) begin
        tests++; fails++;
        $display("FAIL abort_idle%0d: got busy=%b ready=%b cfg=%h want 0/0/0", k, cfg_busy, cfg_ready, config_out);
      end
      tick();
    end
    cfg_valid = 1'b0;
    tests++;
    if (cens != 1 || dones != 0) begin
      fails++; $display("FAIL abort_counts: got cen=%0d done=%0d want 1/0", cens, dones);
    end
  endtask

`ifdef LUTRAM_CFG_PARITY_EN
  task automatic test_parity_error();
    apply_reset();
    run_config(1'b0, 1'b0, 1);
    tests++;
    if (cfg_err !== 1'b1) begin
      fails++; $display("FAIL err_sticky: got %b want 1", cfg_err);
    end
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    tests++;
    if (cfg_err !== 1'b0) begin
      fails++; $display("FAIL err_clear_on_start: got %b want 0", cfg_err);
    end
    apply_reset();
  endtask
`endif

  initial begin
    test_reset();
    test_full_config();
    test_gapped_config();
    test_contention();
    test_writes_during_config();
    test_out_of_range();
    test_mid_config_reset();
`ifdef LUTRAM_CFG_PARITY_EN
    test_parity_error();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
